// File: rtl/adc_trigger.sv
// Qualified trigger generator for adc_controller_pretrig: level/slope/hysteresis
// qualification of the selected ADC channel, external trigger sync, holdoff and auto mode.
module adc_trigger #(
  parameter int DW     = 8,
  parameter int AUTO_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [DW-1:0] adc_a,
  input  logic [DW-1:0] adc_b,
  input  logic          ext_trig,
  input  logic [31:0]   cfg,
  output logic          trigger_req,
  output logic          auto_flag,
  output logic [1:0]    trig_state
);

  // sample_en is a one-clk qualifier with no back-pressure: adc_a/adc_b are only
  // looked at in a clk where it is high; trigger_req is a one-clk pulse with no ack.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRIME   = 2'b01,
    ST_ARMED   = 2'b10,
    ST_HOLDOFF = 2'b11
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_EXT  = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;
  localparam logic [AUTO_W-1:0] AUTO_LAST = {{(AUTO_W-1){1'b1}}, 1'b0};

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_cfg;
  logic [11:0]       r_hold_cnt, w_hold_nxt;
  logic [AUTO_W-1:0] r_auto_cnt, w_auto_nxt;
  logic [1:0]        r_sync;
  logic              r_sync_d;
  logic              r_trig, r_auto;
  logic              w_fire, w_fire_auto;

  logic [DW-1:0] w_level, w_hyst, w_lo, w_hi, w_s;
  logic [DW:0]   w_sum;
  logic          w_src, w_slope;
  logic [1:0]    w_mode;
  logic [11:0]   w_holdoff;
  logic          w_prime_hit, w_level_hit, w_ext_edge, w_cfg_chg, w_auto_hit, w_count;

  assign w_level   = DW'(r_cfg[7:0]);
  assign w_hyst    = DW'(r_cfg[15:8]);
  assign w_src     = r_cfg[16];
  assign w_slope   = r_cfg[17];
  assign w_mode    = r_cfg[19:18];
  assign w_holdoff = r_cfg[31:20];

  // Saturating prime thresholds: the extra sum bit flags overflow past full scale.
  assign w_sum = {1'b0, w_level} + {1'b0, w_hyst};
  assign w_hi  = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
  assign w_lo  = (w_level > w_hyst) ? (w_level - w_hyst) : '0;
  assign w_s   = w_src ? adc_b : adc_a;

  assign w_prime_hit = w_slope ? (w_s >= w_hi) : (w_s <= w_lo);
  assign w_level_hit = w_slope ? (w_s <= w_level) : (w_s >= w_level);
  assign w_ext_edge  = r_sync[1] & ~r_sync_d;
  assign w_cfg_chg   = (cfg != r_cfg);
  assign w_count     = (w_mode == MODE_AUTO) & sample_en;
  assign w_auto_hit  = w_count & (r_auto_cnt == AUTO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_auto_nxt  = r_auto_cnt;
    w_fire      = 1'b0;
    w_fire_auto = 1'b0;
    if (w_cfg_chg) begin
      w_state_nxt = (cfg[19:18] == MODE_OFF) ? ST_IDLE : ST_PRIME;
      w_hold_nxt  = '0;
      w_auto_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mode != MODE_OFF) begin
            w_state_nxt = ST_PRIME;
            w_auto_nxt  = '0;
          end
        end
        ST_PRIME: begin
          if (w_auto_hit) begin
            w_fire      = 1'b1;
            w_fire_auto = 1'b1;
          end else begin
            if ((w_mode == MODE_EXT) || (sample_en && w_prime_hit)) w_state_nxt = ST_ARMED;
            if (w_count) w_auto_nxt = r_auto_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          // A real edge outranks the auto timeout landing on the same sample.
          if ((w_mode == MODE_EXT) ? w_ext_edge : (sample_en && w_level_hit)) begin
            w_fire = 1'b1;
          end else if (w_auto_hit) begin
            w_fire      = 1'b1;
            w_fire_auto = 1'b1;
          end else if (w_count) begin
            w_auto_nxt = r_auto_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == '0) begin
            w_state_nxt = ST_PRIME;
            w_auto_nxt  = '0;
          end else if (sample_en) begin
            w_hold_nxt = r_hold_cnt - 12'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_fire) begin
        w_state_nxt = ST_HOLDOFF;
        w_hold_nxt  = w_holdoff;
        w_auto_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cfg      <= '0;
      r_hold_cnt <= '0;
      r_auto_cnt <= '0;
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      r_trig     <= 1'b0;
      r_auto     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= cfg;
      r_hold_cnt <= w_hold_nxt;
      r_auto_cnt <= w_auto_nxt;
      r_sync     <= {r_sync[0], ext_trig};
      r_sync_d   <= r_sync[1];
      r_trig     <= w_fire;
      r_auto     <= w_fire_auto;
    end
  end

  assign trigger_req = r_trig;
  assign auto_flag   = r_auto;
  assign trig_state  = r_state;

endmodule

// File: tb/tb_adc_trigger.sv
// Bench for adc_trigger: directed scenarios with hand-derived expectations plus a
// cycle-level behavioural model checked on every clk, ending in random stimulus.
module tb_adc_trigger;

  localparam int DW       = 8;
  localparam int AUTO_W   = 4;
  localparam int AUTO_MAX = (1 << AUTO_W) - 1;

  logic          clk = 1'b0;
  logic          rst, sample_en, ext_trig;
  logic [DW-1:0] adc_a, adc_b;
  logic [31:0]   cfg;
  logic          trigger_req, auto_flag;
  logic [1:0]    trig_state;

  int errors = 0;
  int checks = 0;

  // Behavioural model: activity flags plus remaining-holdoff and samples-since-prime counts.
  bit          m_active, m_armed, m_hold;
  int          m_hold_left, m_since;
  logic [31:0] m_cfg;
  bit          m_ext_h[3];
  logic        exp_trig, exp_auto;
  logic [1:0]  exp_state;

  always #5 clk = ~clk;

  adc_trigger #(.DW(DW), .AUTO_W(AUTO_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .adc_a(adc_a), .adc_b(adc_b),
    .ext_trig(ext_trig), .cfg(cfg), .trigger_req(trigger_req), .auto_flag(auto_flag),
    .trig_state(trig_state)
  );

  function automatic logic [31:0] mk_cfg(int lvl, int hy, bit src, bit slope, int mode, int hold);
    return {hold[11:0], mode[1:0], slope, src, hy[7:0], lvl[7:0]};
  endfunction

  task automatic model_step();
    int lvl, hy, lo, hi, s, hold_cfg;
    bit edge_ext, hit, auto_hit, slope;
    logic [1:0] mode;
    edge_ext = m_ext_h[1] && !m_ext_h[2];
    m_ext_h[2] = m_ext_h[1];
    m_ext_h[1] = m_ext_h[0];
    m_ext_h[0] = ext_trig;
    exp_trig = 1'b0;
    exp_auto = 1'b0;
    if (rst) begin
      m_active = 0; m_armed = 0; m_hold = 0; m_hold_left = 0; m_since = 0;
      m_cfg = '0;
      m_ext_h[0] = 0; m_ext_h[1] = 0; m_ext_h[2] = 0;
    end else if (cfg != m_cfg) begin
      m_cfg = cfg;
      m_active = (cfg[19:18] != 2'b00);
      m_armed = 0; m_hold = 0; m_hold_left = 0; m_since = 0;
    end else begin
      mode = m_cfg[19:18];
      lvl = m_cfg[7:0];
      hy = m_cfg[15:8];
      lo = (lvl - hy < 0) ? 0 : lvl - hy;
      hi = (lvl + hy > 255) ? 255 : lvl + hy;
      slope = m_cfg[17];
      s = m_cfg[16] ? int'(adc_b) : int'(adc_a);
      hold_cfg = m_cfg[31:20];
      if (!m_active) begin
        if (mode != 2'b00) begin m_active = 1; m_since = 0; end
      end else if (m_hold) begin
        if (m_hold_left == 0) begin m_hold = 0; m_since = 0; end
        else if (sample_en) m_hold_left--;
      end else begin
        hit = 0;
        if (m_armed) hit = (mode == 2'b10) ? edge_ext : (sample_en && (slope ? s <= lvl : s >= lvl));
        auto_hit = (mode == 2'b11) && sample_en && (m_since + 1 == AUTO_MAX);
        if (hit || auto_hit) begin
          exp_trig = 1'b1;
          exp_auto = !hit;
          m_hold = 1; m_armed = 0; m_hold_left = hold_cfg; m_since = 0;
        end else begin
          if (!m_armed && (mode == 2'b10 || (sample_en && (slope ? s >= hi : s <= lo)))) m_armed = 1;
          if (mode == 2'b11 && sample_en) m_since++;
        end
      end
    end
    exp_state = !m_active ? 2'b00 : m_hold ? 2'b11 : m_armed ? 2'b10 : 2'b01;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      if ({trigger_req, auto_flag, trig_state} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_values t=%0t got=%b want=0000", $time, {trigger_req, auto_flag, trig_state});
      end
      checks++;
    end
    rst = 1'b0;
    repeat (2) begin
      tick();
      if (trig_state !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle_mode_off t=%0t got=%b want=00", $time, trig_state);
      end
      checks++;
    end
  endtask

  task automatic test_rising();
    int pulses = 0, fire_v = -1, fire_k = -1;
    cfg = mk_cfg(128, 8, 0, 0, 1, 0);
    sample_en = 1'b0;
    for (int v = 100; v <= 140; v++) begin
      for (int k = 0; k < 4; k++) begin
        sample_en = (k == 0) && (v > 100);
        adc_a = v[7:0];
        adc_b = DW'($urandom_range(0, 255));
        ext_trig = 1'($urandom_range(0, 1));
        tick();
        if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
          errors++;
          $display("FAIL rising_model t=%0t got=%b want=%b", $time,
                   {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
        end
        checks++;
        if (trigger_req === 1'b1) begin pulses++; fire_v = v; fire_k = k; end
      end
    end
    sample_en = 1'b0;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL rising_pulse_count got=%0d want=1", pulses);
    end
    checks++;
    if (fire_v !== 128 || fire_k !== 0) begin
      errors++;
      $display("FAIL rising_pulse_position got=v%0d/k%0d want=v128/k0", fire_v, fire_k);
    end
    checks++;
  endtask

  task automatic test_noise();
    int dither_pulses = 0, pulses = 0, fire_idx = -1;
    int seq[4] = '{118, 130, 126, 130};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) begin
        sample_en = (k == 0);
        adc_a = (i < 10) ? ((i % 2) ? 8'd130 : 8'd126) : DW'(seq[i-10]);
        adc_b = DW'($urandom_range(0, 255));
        tick();
        if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
          errors++;
          $display("FAIL noise_model t=%0t got=%b want=%b", $time,
                   {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
        end
        checks++;
        if (trigger_req === 1'b1) begin
          if (i < 10) dither_pulses++;
          else begin pulses++; fire_idx = i - 10; end
        end
      end
    end
    sample_en = 1'b0;
    if (dither_pulses !== 0) begin
      errors++;
      $display("FAIL noise_dither_retrigger got=%0d want=0", dither_pulses);
    end
    checks++;
    if (pulses !== 1 || fire_idx !== 1) begin
      errors++;
      $display("FAIL noise_rearm got=%0d pulses at idx %0d want=1 at idx 1", pulses, fire_idx);
    end
    checks++;
  endtask

  task automatic test_falling();
    int b_seq[12] = '{252, 254, 255, 253, 250, 255, 255, 245, 240, 240, 255, 245};
    bit exp_f[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    cfg = mk_cfg(250, 20, 1, 1, 1, 5);
    sample_en = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        sample_en = (k == 0);
        adc_b = DW'(b_seq[i]);
        adc_a = DW'($urandom_range(0, 255));
        tick();
        if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
          errors++;
          $display("FAIL falling_model t=%0t got=%b want=%b", $time,
                   {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
        end
        checks++;
        if (k == 0) begin
          if (trigger_req !== exp_f[i]) begin
            errors++;
            $display("FAIL falling_sample%0d got=%b want=%b", i, trigger_req, exp_f[i]);
          end
          checks++;
        end
      end
    end
    sample_en = 1'b0;
  endtask

  task automatic test_external();
    cfg = mk_cfg(128, 8, 0, 0, 2, 0);
    ext_trig = 1'b0;
    repeat (3) tick();
    for (int t = 0; t < 40; t++) begin
      ext_trig = ((t < 10) || (t >= 20 && t < 35));
      sample_en = 1'($urandom_range(0, 1));
      adc_a = DW'($urandom_range(0, 255));
      tick();
      if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
        errors++;
        $display("FAIL ext_model t=%0t got=%b want=%b", $time,
                 {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
      end
      checks++;
      if (trigger_req !== ((t == 2) || (t == 22))) begin
        errors++;
        $display("FAIL ext_pulse_t%0d got=%b want=%b", t, trigger_req, (t == 2) || (t == 22));
      end
      checks++;
    end
    ext_trig = 1'b0;
    sample_en = 1'b0;
  endtask

  task automatic test_auto();
    logic [7:0] exp_q[$];
    bit want;
    exp_q = '{8'd15, 8'd32, 8'd49};
    cfg = mk_cfg(128, 8, 0, 0, 3, 2);
    sample_en = 1'b0;
    adc_a = 8'd200;
    repeat (2) tick();
    for (int n = 1; n <= 55; n++) begin
      for (int k = 0; k < 3; k++) begin
        sample_en = (k == 0);
        tick();
        if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
          errors++;
          $display("FAIL auto_model t=%0t got=%b want=%b", $time,
                   {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
        end
        checks++;
        if (k == 0) begin
          want = (exp_q.size() > 0) && (exp_q[0] == 8'(n));
          if (want) void'(exp_q.pop_front());
          if ({trigger_req, auto_flag} !== {want, want}) begin
            errors++;
            $display("FAIL auto_sample%0d got=%b want=%b", n, {trigger_req, auto_flag}, {want, want});
          end
          checks++;
        end
      end
    end
    sample_en = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL auto_missing got=%0d left want=0", exp_q.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    cfg = mk_cfg(128, 8, 0, 0, 1, 100);
    sample_en = 1'b0;
    repeat (2) tick();
    sample_en = 1'b1; adc_a = 8'd100; tick();
    sample_en = 1'b0; tick();
    sample_en = 1'b1; adc_a = 8'd200; tick();
    if (trigger_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fire got=%b want=1", trigger_req);
    end
    checks++;
    sample_en = 1'b0; tick();
    if (trig_state !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_holdoff got=%b want=11", trig_state);
    end
    checks++;
    rst = 1'b1; sample_en = 1'b1; tick();
    if ({trigger_req, trig_state} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_idle got=%b want=000", {trigger_req, trig_state});
    end
    checks++;
    rst = 1'b0; sample_en = 1'b0; tick();
    if ({trigger_req, trig_state} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_reprime got=%b want=001", {trigger_req, trig_state});
    end
    checks++;
  endtask

  task automatic test_cfg_armed();
    sample_en = 1'b1; adc_a = 8'd100; tick();
    if (trig_state !== 2'b10) begin
      errors++;
      $display("FAIL cfgarm_armed got=%b want=10", trig_state);
    end
    checks++;
    sample_en = 1'b0; tick();
    cfg = mk_cfg(129, 8, 0, 0, 1, 100);
    sample_en = 1'b1; adc_a = 8'd200; tick();
    if ({trigger_req, trig_state} !== 3'b001) begin
      errors++;
      $display("FAIL cfgarm_suppress got=%b want=001", {trigger_req, trig_state});
    end
    checks++;
    repeat (4) begin
      sample_en = ~sample_en;
      tick();
      if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
        errors++;
        $display("FAIL cfgarm_model t=%0t got=%b want=%b", $time,
                 {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4000; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0)
        cfg = mk_cfg($urandom_range(0, 255), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 6));
      sample_en = ($urandom_range(0, 2) == 0);
      adc_a = DW'($urandom_range(0, 255));
      adc_b = DW'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ext_trig = ~ext_trig;
      tick();
      if ({trigger_req, auto_flag, trig_state} !== {exp_trig, exp_auto, exp_state}) begin
        errors++;
        $display("FAIL random_model t=%0t got=%b want=%b", $time,
                 {trigger_req, auto_flag, trig_state}, {exp_trig, exp_auto, exp_state});
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    ext_trig = 1'b0;
    adc_a = '0;
    adc_b = '0;
    cfg = '0;
    test_reset();
    test_rising();
    test_noise();
    test_falling();
    test_external();
    test_auto();
    test_reset_mid();
    test_cfg_armed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
